// File: rtl/apb_master_arbiter_if.sv
// Bundle of requester-side command/completion signals and the APB bus for the two-requester APB master.
interface apb_master_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  logic [1:0]              req_valid;
  logic [1:0]              req_write;
  logic [2*ADDR_WIDTH-1:0] req_addr;
  logic [2*DATA_WIDTH-1:0] req_wdata;
  logic [2*STRB_WIDTH-1:0] req_strb;
  logic [5:0]              req_prot;
  logic [1:0]              req_done;
  logic                    req_err;
  logic [DATA_WIDTH-1:0]   req_rdata;

  logic [ADDR_WIDTH-1:0]   PADDR;
  logic [2:0]              PPROT;
  logic                    PSEL0;
  logic                    PSEL1;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [DATA_WIDTH-1:0]   PWDATA;
  logic [STRB_WIDTH-1:0]   PSTRB;
  logic                    PREADY;
  logic [DATA_WIDTH-1:0]   PRDATA;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_strb, req_prot, PREADY, PRDATA,
    output req_done, req_err, req_rdata,
    output PADDR, PPROT, PSEL0, PSEL1, PENABLE, PWRITE, PWDATA, PSTRB
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_strb, req_prot, PREADY, PRDATA,
    input  req_done, req_err, req_rdata,
    input  PADDR, PPROT, PSEL0, PSEL1, PENABLE, PWRITE, PWDATA, PSTRB
  );
endinterface

// File: rtl/apb_master_arbiter.sv
// Two-requester round-robin APB master: IDLE/SETUP/ACCESS sequencer with access timeout.
module apb_master_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT    = 16
) (
  input logic                  PCLK,
  input logic                  PRESETn,
  apb_master_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

  localparam int              CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  gnt, gnt_nxt;
  logic                  last, last_nxt;
  logic [ADDR_WIDTH-1:0] paddr, paddr_nxt;
  logic [2:0]            pprot, pprot_nxt;
  logic                  psel0, psel0_nxt;
  logic                  psel1, psel1_nxt;
  logic                  penable, penable_nxt;
  logic                  pwrite, pwrite_nxt;
  logic [DATA_WIDTH-1:0] pwdata, pwdata_nxt;
  logic [STRB_WIDTH-1:0] pstrb, pstrb_nxt;
  logic [DATA_WIDTH-1:0] rdata, rdata_nxt;
  logic [1:0]            done, done_nxt;
  logic                  err, err_nxt;

  logic [1:0]            elig;
  logic                  grant_vld, grant_sel, timeout_hit;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [STRB_WIDTH-1:0] sel_strb;
  logic [2:0]            sel_prot;
  logic                  sel_write;

  // A requester whose done pulse is showing this cycle is still holding valid; it must not re-win.
  assign elig        = bus.req_valid & ~done;
  assign grant_vld   = |elig;
  assign grant_sel   = (elig == 2'b11) ? ~last : elig[1];
  assign timeout_hit = (cnt == CNT_MAX);

  assign sel_addr  = grant_sel ? bus.req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]  : bus.req_addr[ADDR_WIDTH-1:0];
  assign sel_wdata = grant_sel ? bus.req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : bus.req_wdata[DATA_WIDTH-1:0];
  assign sel_strb  = grant_sel ? bus.req_strb[2*STRB_WIDTH-1:STRB_WIDTH]  : bus.req_strb[STRB_WIDTH-1:0];
  assign sel_prot  = grant_sel ? bus.req_prot[5:3] : bus.req_prot[2:0];
  assign sel_write = bus.req_write[grant_sel];

  // last resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state   <= IDLE;
      cnt     <= '0;
      gnt     <= 1'b0;
      last    <= 1'b1;
      paddr   <= '0;
      pprot   <= '0;
      psel0   <= 1'b0;
      psel1   <= 1'b0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      pwdata  <= '0;
      pstrb   <= '0;
      rdata   <= '0;
      done    <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      gnt     <= gnt_nxt;
      last    <= last_nxt;
      paddr   <= paddr_nxt;
      pprot   <= pprot_nxt;
      psel0   <= psel0_nxt;
      psel1   <= psel1_nxt;
      penable <= penable_nxt;
      pwrite  <= pwrite_nxt;
      pwdata  <= pwdata_nxt;
      pstrb   <= pstrb_nxt;
      rdata   <= rdata_nxt;
      done    <= done_nxt;
      err     <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_vld) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (bus.PREADY || timeout_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // APB outputs double as the latched command, so they hold until the transfer ends.
  always_comb begin
    gnt_nxt     = gnt;
    last_nxt    = last;
    cnt_nxt     = cnt;
    paddr_nxt   = paddr;
    pprot_nxt   = pprot;
    psel0_nxt   = psel0;
    psel1_nxt   = psel1;
    penable_nxt = penable;
    pwrite_nxt  = pwrite;
    pwdata_nxt  = pwdata;
    pstrb_nxt   = pstrb;
    rdata_nxt   = rdata;
    done_nxt    = '0;
    err_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (grant_vld) begin
          gnt_nxt     = grant_sel;
          last_nxt    = grant_sel;
          cnt_nxt     = '0;
          paddr_nxt   = sel_addr;
          pprot_nxt   = sel_prot;
          pwrite_nxt  = sel_write;
          pwdata_nxt  = sel_wdata;
          pstrb_nxt   = sel_write ? sel_strb : '0;
          psel0_nxt   = ~sel_addr[ADDR_WIDTH-1];
          psel1_nxt   = sel_addr[ADDR_WIDTH-1];
          penable_nxt = 1'b0;
        end
      end
      SETUP: begin
        penable_nxt = 1'b1;
        cnt_nxt     = CNT_W'(1);
      end
      ACCESS: begin
        if (bus.PREADY || timeout_hit) begin
          psel0_nxt   = 1'b0;
          psel1_nxt   = 1'b0;
          penable_nxt = 1'b0;
          cnt_nxt     = '0;
          done_nxt    = gnt ? 2'b10 : 2'b01;
          err_nxt     = ~bus.PREADY;
          if (!bus.PREADY)     rdata_nxt = '0;
          else if (!pwrite)    rdata_nxt = bus.PRDATA;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.PADDR     = paddr;
  assign bus.PPROT     = pprot;
  assign bus.PSEL0     = psel0;
  assign bus.PSEL1     = psel1;
  assign bus.PENABLE   = penable;
  assign bus.PWRITE    = pwrite;
  assign bus.PWDATA    = pwdata;
  assign bus.PSTRB     = pstrb;
  assign bus.req_done  = done;
  assign bus.req_err   = err;
  assign bus.req_rdata = rdata;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Scoreboard bench for apb_master_arbiter: expected APB setups and completions are queued at issue time.
module tb_apb_master_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  apb_master_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) bus ();

  apb_master_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .TIMEOUT(TO)) dut (
    .PCLK    (clk),
    .PRESETn (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic          sel1;
    logic [AW-1:0] addr;
    logic [2:0]    prot;
    logic          wr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
  } setup_t;

  typedef struct {
    logic [1:0]    done;
    logic          err;
    logic [DW-1:0] rdata;
    int            acc_len;
  } cpl_t;

  setup_t        setup_q[$];
  cpl_t          cpl_q[$];
  int            n_chk = 0;
  int            n_err = 0;
  int            wait_n = 0;
  bit            stuck = 1'b0;
  bit            idle_ready = 1'b0;
  logic [DW-1:0] model_rdata = '0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [SW-1:0] strb, input logic [2:0] prot);
    bus.req_write[i]         = wr;
    bus.req_addr[i*AW +: AW] = addr;
    bus.req_wdata[i*DW +: DW] = wdata;
    bus.req_strb[i*SW +: SW] = strb;
    bus.req_prot[i*3 +: 3]   = prot;
    bus.req_valid[i]         = 1'b1;
  endtask

  task automatic expect_xfer(input int i, input logic wr, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata, input logic [SW-1:0] strb, input logic [2:0] prot,
                             input int acc_len, input logic err, input logic [DW-1:0] rd, input bit with_cpl);
    setup_t s;
    cpl_t   c;
    s.sel1  = addr[AW-1];
    s.addr  = addr;
    s.prot  = prot;
    s.wr    = wr;
    s.wdata = wdata;
    s.strb  = wr ? strb : '0;
    setup_q.push_back(s);
    if (with_cpl) begin
      if (err)      model_rdata = '0;
      else if (!wr) model_rdata = rd;
      c.done    = (i == 1) ? 2'b10 : 2'b01;
      c.err     = err;
      c.rdata   = model_rdata;
      c.acc_len = acc_len;
      cpl_q.push_back(c);
    end
  endtask

  task automatic issue(input int i, input logic wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input logic [SW-1:0] strb, input logic [2:0] prot,
                       input int acc_len, input logic err, input logic [DW-1:0] rd);
    set_req(i, wr, addr, wdata, strb, prot);
    expect_xfer(i, wr, addr, wdata, strb, prot, acc_len, err, rd, 1'b1);
  endtask

  task automatic wait_dones(input int n, input int budget, input bit drop);
    int seen = 0;
    int cyc  = 0;
    while (seen < n && cyc < budget) begin
      step();
      cyc++;
      if (bus.req_done != 2'b00) begin
        seen++;
        if (drop) bus.req_valid = bus.req_valid & ~bus.req_done;
      end
    end
    chk("done_count", 128'(seen), 128'(n));
  endtask

  // Slave model: PREADY rises after wait_n ACCESS cycles unless stuck; idle_ready drives it outside ACCESS.
  initial begin
    int acc_cnt;
    acc_cnt    = 0;
    bus.PREADY = 1'b0;
    forever begin
      @(negedge clk);
      if ((bus.PSEL0 || bus.PSEL1) && bus.PENABLE) begin
        acc_cnt++;
        bus.PREADY = !stuck && (acc_cnt > wait_n);
      end else begin
        acc_cnt    = 0;
        bus.PREADY = idle_ready;
      end
    end
  end

  // Monitor: setup phases and completions are checked against the queues.
  initial begin
    setup_t cur;
    setup_t s;
    cpl_t   c;
    int     acc;
    bit     prev_acc;
    bit     in_acc;
    acc      = 0;
    prev_acc = 1'b0;
    cur      = '{default: '0};
    forever begin
      @(negedge clk);
      in_acc = (bus.PSEL0 || bus.PSEL1) && bus.PENABLE;
      if (bus.PSEL0 || bus.PSEL1) chk("psel_excl", 128'(bus.PSEL0 & bus.PSEL1), 128'(0));
      if (bus.req_done == 2'b00) chk("err_idle", 128'(bus.req_err), 128'(0));
      if ((bus.PSEL0 || bus.PSEL1) && !bus.PENABLE) begin
        if (setup_q.size() == 0) begin
          chk("setup_unexp", 128'(1), 128'(0));
        end else begin
          s   = setup_q.pop_front();
          cur = s;
          acc = 0;
          chk("setup_sel",   128'({bus.PSEL1, bus.PSEL0}), 128'({s.sel1, ~s.sel1}));
          chk("setup_addr",  128'(bus.PADDR), 128'(s.addr));
          chk("setup_ctl",   128'({bus.PPROT, bus.PWRITE, bus.PSTRB}), 128'({s.prot, s.wr, s.strb}));
          chk("setup_wdata", 128'(bus.PWDATA), 128'(s.wdata));
        end
      end
      if (in_acc) begin
        acc++;
        chk("access_hold",
            128'({bus.PSEL1, bus.PSEL0, bus.PADDR, bus.PPROT, bus.PWRITE, bus.PWDATA, bus.PSTRB}),
            128'({cur.sel1, ~cur.sel1, cur.addr, cur.prot, cur.wr, cur.wdata, cur.strb}));
      end
      if (bus.req_done != 2'b00) begin
        if (cpl_q.size() == 0) begin
          chk("done_unexp", 128'(bus.req_done), 128'(0));
        end else begin
          c = cpl_q.pop_front();
          chk("done_vec",   128'(bus.req_done), 128'(c.done));
          chk("done_err",   128'(bus.req_err), 128'(c.err));
          chk("done_rdata", 128'(bus.req_rdata), 128'(c.rdata));
          chk("acc_len",    128'(acc), 128'(c.acc_len));
          chk("done_after_access", 128'(prev_acc), 128'(1));
          chk("done_bus_idle", 128'({bus.PSEL0, bus.PSEL1, bus.PENABLE}), 128'(0));
        end
      end
      prev_acc = in_acc;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_strb  = '0;
    bus.req_prot  = '0;
    bus.PRDATA    = '0;

    #1 rst_n = 1'b0;
    #1;
    chk("rst_outputs", 128'({bus.PADDR, bus.PPROT, bus.PSEL0, bus.PSEL1, bus.PENABLE, bus.PWRITE,
                              bus.PWDATA, bus.PSTRB, bus.req_done, bus.req_err, bus.req_rdata}), 128'(0));
    repeat (2) step();
    rst_n = 1'b1;

    // Contention from reset: both held valid, grants alternate starting with requester 0.
    bus.PRDATA = 32'h0BAD_F00D;
    wait_n     = 2;
    set_req(0, 1'b0, 32'h0000_0008, 32'h0, 4'hF, 3'b001);
    set_req(1, 1'b1, 32'h8000_000C, 32'h1122_3344, 4'hC, 3'b110);
    for (int k = 0; k < 2; k++) begin
      expect_xfer(0, 1'b0, 32'h0000_0008, 32'h0, 4'hF, 3'b001, 3, 1'b0, 32'h0BAD_F00D, 1'b1);
      expect_xfer(1, 1'b1, 32'h8000_000C, 32'h1122_3344, 4'hC, 3'b110, 3, 1'b0, 32'h0BAD_F00D, 1'b1);
    end
    wait_dones(4, 100, 1'b0);
    bus.req_valid = '0;
    step();

    // Single write; valid lingers through the done cycle and must not re-grant.
    wait_n = 0;
    issue(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'b000, 1, 1'b0, 32'h0);
    wait_dones(1, 20, 1'b0);
    step();
    bus.req_valid = '0;
    step();

    // Read with three wait states; PREADY high outside ACCESS must be ignored.
    idle_ready = 1'b1;
    wait_n     = 3;
    bus.PRDATA = 32'h1234_5678;
    issue(1, 1'b0, 32'h8000_0004, 32'hFFFF_FFFF, 4'hF, 3'b101, 4, 1'b0, 32'h1234_5678);
    wait_dones(1, 30, 1'b1);
    step();

    // Write to the upper slave keeps the previous read data.
    idle_ready = 1'b0;
    wait_n     = 1;
    bus.PRDATA = 32'h5555_AAAA;
    issue(0, 1'b1, 32'h8000_0020, 32'hCAFE_F00D, 4'h5, 3'b010, 2, 1'b0, 32'h5555_AAAA);
    wait_dones(1, 30, 1'b1);
    step();

    // Timeout: PREADY never rises.
    stuck      = 1'b1;
    bus.PRDATA = 32'hA5A5_A5A5;
    issue(1, 1'b0, 32'h0000_0040, 32'h0, 4'hF, 3'b000, TO, 1'b1, 32'hA5A5_A5A5);
    wait_dones(1, 40, 1'b1);
    stuck = 1'b0;
    step();

    // Reset in the middle of ACCESS.
    stuck = 1'b1;
    set_req(0, 1'b0, 32'h0000_0100, 32'h0, 4'h3, 3'b000);
    expect_xfer(0, 1'b0, 32'h0000_0100, 32'h0, 4'h3, 3'b000, 0, 1'b0, 32'h0, 1'b0);
    g = 0;
    while (!bus.PENABLE && g < 10) begin
      step();
      g++;
    end
    chk("reach_access", 128'(bus.PENABLE), 128'(1));
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async", 128'({bus.PSEL0, bus.PSEL1, bus.PENABLE, bus.req_done, bus.req_err}), 128'(0));
    model_rdata = '0;
    set_req(1, 1'b1, 32'h8000_0030, 32'h0102_0304, 4'hF, 3'b011);
    stuck      = 1'b0;
    wait_n     = 0;
    bus.PRDATA = 32'h600D_CAFE;
    expect_xfer(0, 1'b0, 32'h0000_0100, 32'h0, 4'h3, 3'b000, 1, 1'b0, 32'h600D_CAFE, 1'b1);
    expect_xfer(1, 1'b1, 32'h8000_0030, 32'h0102_0304, 4'hF, 3'b011, 1, 1'b0, 32'h0, 1'b1);
    step();
    chk("rst_hold_done", 128'(bus.req_done), 128'(0));
    step();
    rst_n = 1'b1;
    wait_dones(2, 30, 1'b1);
    repeat (2) step();

    chk("setup_q_drained", 128'(setup_q.size()), 128'(0));
    chk("cpl_q_drained",   128'(cpl_q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/apb_master_arbiter.md
APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, APB address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, APB data width (multiple of 8).
REQ-003 The block SHALL have parameter STRB_WIDTH, default DATA_WIDTH/8, byte-strobe width.
REQ-004 The block SHALL have parameter TIMEOUT, default 16, max ACCESS cycles before abort (>=2).
REQ-005 The block SHALL have ports:
PCLK  in  1  clock, all state on rising edge.
PRESETn  in  1  reset, asynchronous, active-low.
req_valid  in  2  bit i = requester i has a pending transfer.
req_write  in  2  bit i: 1 write, 0 read.
req_addr  in  2*ADDR_WIDTH  slice i = requester i address.
req_wdata  in  2*DATA_WIDTH  slice i = write data.
req_strb  in  2*STRB_WIDTH  slice i = byte strobes.
req_prot  in  6  slice i (3 bits) = protection.
req_done  out  2  bit i pulses 1 cycle on completion of requester i's transfer.
req_err  out  1  valid with req_done: 1 = timeout abort.
req_rdata  out  DATA_WIDTH  read data, valid with req_done.
PADDR  out  ADDR_WIDTH  APB address.
PPROT  out  3  APB protection.
PSEL0, PSEL1  out  1 each  slave selects.
PENABLE  out  1  APB enable.
PWRITE  out  1  APB direction.
PWDATA  out  DATA_WIDTH  APB write data.
PSTRB  out  STRB_WIDTH  APB strobes.
PREADY  in  1  slave ready.
PRDATA  in  DATA_WIDTH  slave read data.

Function
REQ-006 FSM states SHALL be IDLE, SETUP, ACCESS; all APB outputs registered.
REQ-007 In IDLE, req_valid[i] SHALL be considered only when req_done[i] is 0 in that cycle.
REQ-008 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; with one valid, grant it.
REQ-009 On grant in IDLE, command SHALL be latched and FSM SHALL enter SETUP next cycle; later changes to req_* are ignored until req_done.
REQ-010 SETUP (exactly 1 cycle): PSEL0=1 if PADDR[ADDR_WIDTH-1]==0 else PSEL1=1; PENABLE=0; PADDR/PPROT/PWRITE/PWDATA driven from latched command.
REQ-011 PSTRB SHALL equal latched strobes for writes and 0 for reads.
REQ-012 ACCESS: PENABLE=1, PSEL and all APB outputs held stable until exit.
REQ-013 ACCESS with PREADY=1: next cycle FSM SHALL be IDLE, PSEL/PENABLE=0, req_done[g]=1, req_err=0, req_rdata=PRDATA for reads (unchanged for writes).
REQ-014 A cycle counter SHALL count ACCESS cycles; if PREADY is still 0 in ACCESS cycle TIMEOUT, FSM SHALL go IDLE with req_done[g]=1, req_err=1, req_rdata=0.
REQ-015 PREADY SHALL be ignored outside ACCESS.
REQ-016 Minimum transfer SHALL be 3 cycles (IDLE grant, SETUP, ACCESS); done pulse coincides with next IDLE cycle.
REQ-017 req_done SHALL be one-hot or zero and last exactly one cycle; req_err SHALL be 0 whenever req_done==0.
REQ-018 PSEL0 and PSEL1 SHALL never be asserted together.

Reset
REQ-019 PRESETn=0 SHALL immediately force IDLE, all outputs 0, counter 0, round-robin pointer so requester 0 wins the first tie.
REQ-020 Reset mid-transfer SHALL abort it with no req_done pulse; first grant after release follows REQ-019.

Verification
REQ-021 Single write: req0 addr=0x0000_0010, wdata=0xDEADBEEF, strb=0xF, PREADY=1 in first ACCESS -> PSEL0 SETUP then ACCESS, PWDATA=0xDEADBEEF, PSTRB=0xF, req_done=2'b01 3 cycles after grant, req_err=0.
REQ-022 Read with waits: req1 read addr=0x8000_0004, PREADY low 3 ACCESS cycles, PRDATA=0x12345678 -> PSEL1 only, PSTRB=0, req_rdata=0x12345678, req_done=2'b10.
REQ-023 Contention: both valid from reset, held through 4 transfers -> grant order 0,1,0,1.
REQ-024 Timeout: TIMEOUT=16, PREADY stuck 0 -> exactly 16 ACCESS cycles, then req_done pulse, req_err=1, req_rdata=0, PSEL/PENABLE=0.
REQ-025 Reset during ACCESS: PRESETn low mid-transfer -> PSEL/PENABLE 0 without clock edge, no req_done; after release with both valid, requester 0 granted first.
